mux_pipe_tree_n: RTL
====================

// Module: mux_pipe_tree_n
// PURPOSE
//   Registered, parametrised 2**address:1 word selector built as a radix-2**s tree.
//   One pipeline register per tree level; a valid bit and the unused select bits travel with the data.
//   Wide table/register-file read paths (2048+ entries) close timing at full clock rate.
//   Throughput: one selection per cycle.
// PARAMETERS
//   n        32  word width in bits
//   address  11  select width; number of inputs = 2**address
//   s        4   select bits consumed per level (radix 2**s); 1 <= s <= address
//   STAGES   derived = ceil(address/s); localparam, not overridable
// PORTS
//   clk_i    in   1                  clock, rising edge
//   rst_i    in   1                  asynchronous, active-high reset
//   valid_i  in   1                  sample data_i/sel this cycle
//   data_i   in   n x 2**address     unpacked array [0:2**address-1]
//   sel      in   address            index of word to forward
//   valid_o  out  1                  data_o holds a result
//   data_o   out  n                  selected word, registered
//   ready_i  in   1                  downstream accepts (MUXP_STALL_EN only)
//   ready_o  out  1                  input accepted this cycle (MUXP_STALL_EN only)
// BEHAVIOUR
//   - Level k (k = 0..STAGES-1) reduces groups of 2**s words to 1 using sel[min(s*(k+1),address)-1 : s*k].
//   - Decoding is LSB-first. The last level consumes the remaining address - s*(STAGES-1) bits.
//     Defaults: levels of 4, 4, 3 bits.
//   - Level k registers: its reduced word array, valid bit, and sel bits still needed by later levels.
//     Level STAGES-1 output is data_o/valid_o.
//   - Latency: valid_i=1 at edge T gives valid_o=1 with data_o=data_i[sel] after edge T+STAGES-1.
//     Visible STAGES cycles after presentation.
//   - valid_i=0 inserts a bubble. Data registers may load, but valid stays 0.
//   - Per-level valid is a shift chain; data/sel registers at a level load only when that level is enabled.
//   - Reset: all valid bits 0, data_o = 0, all internal data/sel registers 0. Takes effect immediately (async).
//     First valid_o = 1 is no earlier than STAGES edges after deassertion.
//   - Reset mid-operation flushes every in-flight selection. No partial results emerge.
//   - sel = 0 and sel = 2**address-1 are ordinary cases; there is no wrap or out-of-range index.
//   - Back-to-back valid_i with changing sel: each result appears in order, one per cycle, no mixing.
//   - Levels are plain registers. No combinational path from data_i/sel to data_o.
// CONFIGURATION
//   Macro MUXP_STALL_EN
//   - Defined: ready_i/ready_o ports exist.
//     - en = ready_i | ~valid_o; ready_o = en.
//     - All levels advance only when en=1, otherwise hold every register.
//     - An input with valid_i=1 and ready_o=0 is not captured; the source must hold it.
//     - A result is consumed on valid_o & ready_i.
//     - valid_o and data_o stay stable while valid_o=1 and ready_i=0.
//     - Internal bubbles are not compacted.
//   - Undefined: ports absent; en = 1 constantly. Each result is presented for exactly one cycle.
// TESTING
//   1 Reset: assert rst_i mid-cycle with 3 valids in flight -> valid_o=0, data_o=0 at once; nothing emerges after release.
//   2 Latency: data_i[k]=k*3+1, valid_i=1, sel=11'd1234 for 1 cycle -> valid_o=1, data_o=3703, exactly 3 cycles later, single cycle.
//   3 Bounds: sel=0, then sel=2047 back-to-back -> data_o=1 then 6142 on consecutive cycles.
//   4 Streaming: 100 random sels, valid_i=1 every cycle -> 100 in-order matches vs model, valid_o never drops mid-burst.
//   5 Bubbles: valid_i pattern 1,0,1,1,0 -> valid_o pattern 1,0,1,1,0 shifted by STAGES.
//   6 MUXP_STALL_EN: ready_i=0 for 5 cycles with output valid, valid_i held.
//     -> data_o/valid_o stable, ready_o=0, no loss/duplicate.
//     -> After release, order is preserved.
//   Params: rerun 2-4 with n=8, address=5, s=2 (STAGES=3, last level 1 bit).

Source files
------------

// File: rtl/mux_pipe_tree_n.sv
// Registered 2**address:1 word selector built as a radix-2**s tree, one register per level.
// Optional MUXP_STALL_EN adds a ready/valid backpressure handshake on the output.
module mux_pipe_tree_n #(
    parameter int n       = 32,
    parameter int address = 11,
    parameter int s       = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [n-1:0]       data_i [0:2**address-1],
    input  logic [address-1:0] sel,
`ifdef MUXP_STALL_EN
    input  logic               ready_i,
    output logic               ready_o,
`endif
    output logic               valid_o,
    output logic [n-1:0]       data_o
);

    localparam int STAGES = (address + s - 1) / s;

    logic en;

`ifdef MUXP_STALL_EN
    // A held result blocks the whole pipe; bubbles inside are not squeezed out.
    assign en      = ready_i | ~valid_o;
    assign ready_o = en;
`else
    assign en = 1'b1;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_lvl
        localparam int LO      = s * k;
        localparam int HI      = (s * (k + 1) < address) ? s * (k + 1) : address;
        localparam int W       = HI - LO;
        localparam int IW      = address - LO;
        localparam int REM     = address - HI;
        localparam int IN_CNT  = 1 << IW;
        localparam int OUT_CNT = 1 << REM;

        logic [n-1:0]  din [IN_CNT];
        logic [IW-1:0] sin;
        logic          vin;

        logic [n-1:0]  data_d [OUT_CNT];
        logic [n-1:0]  data_q [OUT_CNT];
        logic          vld_d;
        logic          vld_q;
        logic [IW-1:0] idx;

        if (k == 0) begin : g_src
            assign din = data_i;
            assign sin = sel;
            assign vin = valid_i;
        end else begin : g_src
            assign din = g_lvl[k-1].data_q;
            assign sin = g_lvl[k-1].g_sel.sel_q;
            assign vin = g_lvl[k-1].vld_q;
        end

        // Level k boundary: each group of 2**W contiguous words collapses to one,
        // picked by the lowest W select bits still carried.
        always_comb begin
            idx = '0;
            for (int j = 0; j < OUT_CNT; j++) begin
                idx         = IW'(j) << W;
                idx[W-1:0]  = sin[W-1:0];
                data_d[j]   = din[idx];
            end
            vld_d = vin;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q <= 1'b0;
                for (int j = 0; j < OUT_CNT; j++) begin
                    data_q[j] <= '0;
                end
            end else if (en) begin
                vld_q  <= vld_d;
                data_q <= data_d;
            end
        end

        if (REM > 0) begin : g_sel
            logic [REM-1:0] sel_d;
            logic [REM-1:0] sel_q;

            always_comb begin
                sel_d = sin[IW-1:W];
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sel_q <= '0;
                end else if (en) begin
                    sel_q <= sel_d;
                end
            end
        end
    end

    assign valid_o = g_lvl[STAGES-1].vld_q;
    assign data_o  = g_lvl[STAGES-1].data_q[0];

endmodule
